// File: rtl/qpsk_tx_pkg.sv
// Shared constants for the QPSK transmit symbol path.
package qpsk_tx_pkg;

  // PRBS9 register width and polynomial x^9+x^5+1 tap positions
  localparam int LFSR_W = 9;
  localparam int TAP_HI = 8;
  localparam int TAP_LO = 4;

  // Two's complement impulse encodings; bit 1 maps to the negative level
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b11;
  localparam logic [1:0] SYM_ZERO = 2'b00;

  // Default seeds and the substitute used when a zero seed would lock up
  localparam logic [LFSR_W-1:0] SEED_I_DEF   = 9'h1AA;
  localparam logic [LFSR_W-1:0] SEED_Q_DEF   = 9'h1FE;
  localparam logic [LFSR_W-1:0] SEED_NONZERO = 9'h1FF;

  // Same sign convention as the RX slicer: bit 1 is a negative sample
  function automatic logic [1:0] mapSym(input logic b);
    return b ? SYM_NEG : SYM_POS;
  endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// Fibonacci PRBS9 generator; o_bit is the bit emitted on the next step.
import qpsk_tx_pkg::*;

module prbs9_lfsr #(
  parameter logic [LFSR_W-1:0] RESET_SEED = SEED_I_DEF
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_step,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic              o_bit
);

  logic [LFSR_W-1:0] r;

  // Reseed (zero seed replaced) or shift in the feedback on each symbol step
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)
      r <= RESET_SEED;
    else if (i_load)
      r <= (i_seed == '0) ? SEED_NONZERO : i_seed;
    else if (i_step)
      r <= {r[LFSR_W-2:0], r[TAP_HI] ^ r[TAP_LO]};
  end

  assign o_bit = r[TAP_HI];

endmodule

// File: rtl/prbs_upsampler_tx.sv
// PRBS9 I/Q symbol source with zero-insertion upsampling by OS.
import qpsk_tx_pkg::*;

module prbs_upsampler_tx #(
  parameter int                OS     = 4,
  parameter logic [LFSR_W-1:0] SEED_I = SEED_I_DEF,
  parameter logic [LFSR_W-1:0] SEED_Q = SEED_Q_DEF,
  parameter int                PH_W   = 2
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_load,
  input  logic [8:0]        i_seedI,
  input  logic [8:0]        i_seedQ,
  output logic signed [1:0] o_upI,
  output logic signed [1:0] o_upQ,
  output logic              o_bitI,
  output logic              o_bitQ,
  output logic              o_strobe,
  output logic [PH_W-1:0]   o_phase
);

  localparam logic [1:0][LFSR_W-1:0] RST_SEEDS = {SEED_Q, SEED_I};

  logic [PH_W-1:0]          phase;
  logic                     symEvent;
  logic [1:0]               laneBit;
  logic [1:0][LFSR_W-1:0]   seeds;

  // Load wins over enable, so a load cycle never advances the sequence
  assign symEvent = i_enable && !i_load && (phase == '0);
  assign seeds    = {i_seedQ, i_seedI};

  // Lane 0 is I, lane 1 is Q; identical generators with separate state
  for (genvar g = 0; g < 2; g++) begin : gLane
    prbs9_lfsr #(.RESET_SEED(RST_SEEDS[g])) uLfsr (
      .clock   (clock),
      .i_reset (i_reset),
      .i_step  (symEvent),
      .i_load  (i_load),
      .i_seed  (seeds[g]),
      .o_bit   (laneBit[g])
    );
  end

  // Sample phase within the symbol, wrapping at OS-1
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)
      phase <= '0;
    else if (i_load)
      phase <= '0;
    else if (i_enable)
      phase <= (phase == PH_W'(OS - 1)) ? '0 : phase + 1'b1;
  end

  // Registered impulse outputs: symbol on phase 0, zeros in between
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_upI    <= SYM_ZERO;
      o_upQ    <= SYM_ZERO;
      o_bitI   <= 1'b0;
      o_bitQ   <= 1'b0;
      o_strobe <= 1'b0;
      o_phase  <= '0;
    end else if (i_load) begin
      o_upI    <= SYM_ZERO;
      o_upQ    <= SYM_ZERO;
      o_strobe <= 1'b0;
      o_phase  <= '0;
    end else if (i_enable) begin
      o_strobe <= symEvent;
      o_phase  <= phase;
      if (symEvent) begin
        o_bitI <= laneBit[0];
        o_bitQ <= laneBit[1];
        o_upI  <= mapSym(laneBit[0]);
        o_upQ  <= mapSym(laneBit[1]);
      end else begin
        o_upI  <= SYM_ZERO;
        o_upQ  <= SYM_ZERO;
      end
    end else begin
      o_strobe <= 1'b0;
    end
  end

endmodule
